// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Contents:
//   GROUP_W            - lookahead group width (the only supported group size)
//   MAX_PG_W           - widest generate/propagate vector the helpers accept
//   num_groups()       - number of lookahead groups for a given operand width
//   grp_prop()/grp_gen() - group propagate / group generate in flat
//                        sum-of-products form (no ripple through the group)
package cla_pkg;

    localparam int GROUP_W  = 4;
    localparam int MAX_PG_W = 64;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Group propagate: every bit of the group propagates.
    function automatic logic grp_prop(input logic [MAX_PG_W-1:0] p, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_PG_W; i++) begin
            if (i < n) r = r & p[i];
        end
        return r;
    endfunction

    // Group generate: OR over bit j of (g[j] & p[n-1:j+1]).
    function automatic logic grp_gen(input logic [MAX_PG_W-1:0] p,
                                     input logic [MAX_PG_W-1:0] g,
                                     input int n);
        logic r;
        logic term;
        r = 1'b0;
        for (int j = 0; j < MAX_PG_W; j++) begin
            term = g[j];
            for (int k = 0; k < MAX_PG_W; k++) begin
                if (k > j && k < n) term = term & p[k];
            end
            if (j < n) r = r | term;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group_pg.sv
// One lookahead group.
// Ports:
//   p, g   - per-bit propagate / generate of the group (GROUP bits)
//   cin    - carry into bit 0 of the group
//   c      - carry into each bit of the group (c[0] == cin)
//   grp_p  - group propagate (independent of cin)
//   grp_g  - group generate  (independent of cin)
// Used both for the bit-level groups and for the group-of-groups level,
// where GROUP is the number of bit-level groups.
module cla_group_pg
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic [GROUP-1:0] c,
    output logic             grp_p,
    output logic             grp_g
);

    logic [MAX_PG_W-1:0] p_ext;
    logic [MAX_PG_W-1:0] g_ext;
    logic                term;

    always_comb begin
        p_ext            = '0;
        g_ext            = '0;
        p_ext[GROUP-1:0] = p;
        g_ext[GROUP-1:0] = g;
    end

    // Kept separate from the carry logic so group P/G never depend on cin.
    assign grp_p = grp_prop(p_ext, GROUP);
    assign grp_g = grp_gen(p_ext, g_ext, GROUP);

    // Every carry is a flat OR of product terms: cin propagated through all
    // lower bits, or some lower bit generating and all bits above it propagating.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = c[i] | term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - operand handshake
//   a, b, c_in, sub     - operands; sub=1 computes a-b (c_in ignored)
//   out_valid, out_ready- result handshake
//   sum, c_out          - result and unsigned carry-out (sub: 1 = no borrow)
//   overflow, zero      - signed overflow, sum==0
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_GROUPS = WIDTH / GROUP;

    if (GROUP != GROUP_W || (WIDTH % GROUP) != 0 || WIDTH < 4 ||
        num_groups(WIDTH) > MAX_PG_W) begin : g_bad_params
        $error("pipelined_cla_adder: illegal WIDTH=%0d / GROUP=%0d", WIDTH, GROUP);
    end

    // ---- stage 0: operand conditioning and two-level lookahead ----
    logic [WIDTH-1:0]      b_eff;
    logic                  cin_eff;
    logic [WIDTH-1:0]      p_bits;
    logic [WIDTH-1:0]      g_bits;
    logic [WIDTH-1:0]      c_bits;
    logic [NUM_GROUPS-1:0] gp;
    logic [NUM_GROUPS-1:0] gg;
    logic [NUM_GROUPS-1:0] gc;
    logic                  top_p;
    logic                  top_g;
    logic                  cout_bits;

    assign b_eff   = b ^ {WIDTH{sub}};
    assign cin_eff = sub | c_in;
    assign p_bits  = a ^ b_eff;
    assign g_bits  = a & b_eff;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
        cla_group_pg #(.GROUP(GROUP)) u_grp (
            .p     (p_bits[k*GROUP +: GROUP]),
            .g     (g_bits[k*GROUP +: GROUP]),
            .cin   (gc[k]),
            .c     (c_bits[k*GROUP +: GROUP]),
            .grp_p (gp[k]),
            .grp_g (gg[k])
        );
    end

    cla_group_pg #(.GROUP(NUM_GROUPS)) u_top (
        .p     (gp),
        .g     (gg),
        .cin   (cin_eff),
        .c     (gc),
        .grp_p (top_p),
        .grp_g (top_g)
    );

    assign cout_bits = top_g | (top_p & cin_eff);

    // ---- handshake control ----
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic s1_adv;
    logic in_hs;
    logic s1_move;

    assign s1_adv   = ~vld_p2_q | out_ready;
    assign in_ready = ~vld_p1_q | s1_adv;
    assign in_hs    = in_valid & in_ready;
    assign s1_move  = vld_p1_q & s1_adv;

    always_comb begin
        vld_p1_d = vld_p1_q;
        if (in_hs)       vld_p1_d = 1'b1;
        else if (s1_adv) vld_p1_d = 1'b0;

        vld_p2_d = vld_p2_q;
        if (s1_move)        vld_p2_d = 1'b1;
        else if (out_ready) vld_p2_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // ---- stage 1 registers: propagate, carries, sign bits ----
    logic [WIDTH-1:0] p_p1_q, p_p1_d;
    logic [WIDTH-1:0] c_p1_q, c_p1_d;
    logic             cout_p1_q, cout_p1_d;
    logic             a_msb_p1_q, a_msb_p1_d;
    logic             b_msb_p1_q, b_msb_p1_d;

    always_comb begin
        p_p1_d     = p_p1_q;
        c_p1_d     = c_p1_q;
        cout_p1_d  = cout_p1_q;
        a_msb_p1_d = a_msb_p1_q;
        b_msb_p1_d = b_msb_p1_q;
        if (in_hs) begin
            p_p1_d     = p_bits;
            c_p1_d     = c_bits;
            cout_p1_d  = cout_bits;
            a_msb_p1_d = a[WIDTH-1];
            b_msb_p1_d = b_eff[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        p_p1_q     <= p_p1_d;
        c_p1_q     <= c_p1_d;
        cout_p1_q  <= cout_p1_d;
        a_msb_p1_q <= a_msb_p1_d;
        b_msb_p1_q <= b_msb_p1_d;
    end

    // ---- stage 2 registers: final sum and flags ----
    logic [WIDTH-1:0] sum_new;
    logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
    logic             cout_p2_q, cout_p2_d;
    logic             ovf_p2_q, ovf_p2_d;
    logic             zero_p2_q, zero_p2_d;

    assign sum_new = p_p1_q ^ c_p1_q;

    always_comb begin
        sum_p2_d  = sum_p2_q;
        cout_p2_d = cout_p2_q;
        ovf_p2_d  = ovf_p2_q;
        zero_p2_d = zero_p2_q;
        if (s1_move) begin
            sum_p2_d  = sum_new;
            cout_p2_d = cout_p1_q;
            ovf_p2_d  = (a_msb_p1_q == b_msb_p1_q) & (sum_new[WIDTH-1] != a_msb_p1_q);
            zero_p2_d = ~|sum_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            zero_p2_q <= 1'b1;
        end else begin
            sum_p2_q  <= sum_p2_d;
            cout_p2_q <= cout_p2_d;
            ovf_p2_q  <= ovf_p2_d;
            zero_p2_q <= zero_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign sum       = sum_p2_q;
    assign c_out     = cout_p2_q;
    assign overflow  = ovf_p2_q;
    assign zero      = zero_p2_q;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of GROUP and at least 4.
REQ-002 Parameter GROUP, default 4: bits per lookahead group; only 4 is supported.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand beat is valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 c_in  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  mode: 0 = a+b+c_in, 1 = a-b, computed as a+~b+1.
REQ-010 out_valid  output  1  result beat is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 c_out, overflow, zero  output  1 each  carry-out of the MSB, signed overflow, and (sum==0).

Function
REQ-014 Transfer rule: input handshake when in_valid&in_ready; output handshake when out_valid&out_ready.
REQ-015 Two register stages, S1 and S2, each with its own valid bit.
- S1 advance: s1_adv = ~s2_valid | out_ready.
- in_ready = ~s1_valid | s1_adv, combinational, with no dependence on in_valid.
REQ-016 S1 captures on input handshake:
- effective b = b^{WIDTH{sub}} and effective carry = sub ? 1 : c_in;
- per-bit p = a^b_eff and g = a&b_eff;
- per-group P/G and group carries from the two-level lookahead (groups, then group-of-groups);
- a[MSB] and b_eff[MSB].
REQ-017 S2 captures S1 contents when s1_valid & s1_adv.
- S2 computes sum = p ^ {carries};
- c_out = final carry;
- overflow = (a_msb==b_eff_msb) & (sum_msb!=a_msb);
- zero = ~|sum.
REQ-018 Latency SHALL be exactly 2 cycles from input handshake to out_valid when out_ready is held 1.
- Throughput: one beat per cycle.
REQ-019 When out_valid=1 and out_ready=0:
- sum, c_out, overflow, zero SHALL be held stable;
- S1 SHALL retain its contents;
- in_ready SHALL drop only if s1_valid=1.
REQ-020 S1 data registers SHALL load only on input handshake; S2 data registers SHALL load only when S1 advances.
REQ-021 When S1 advances and no new input handshake occurs in the same cycle, s1_valid SHALL clear.
- Simultaneous advance and new input handshake SHALL replace S1 contents with no loss or duplication.
REQ-022 No bubble insertion: a full pipeline with out_ready=1 and in_valid=1 SHALL stream continuously.
REQ-023 Carry chain: no ripple longer than one group in either stage.
- Carries SHALL be derived from GROUP-wide generate/propagate lookahead equations.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; c_out SHALL be the unsigned carry (for sub=1, c_out=1 means no borrow).

Reset
REQ-025 rst=1 SHALL asynchronously clear s1_valid and s2_valid, making out_valid=0 and in_ready=1 immediately.
REQ-026 During reset, sum=0, c_out=0, overflow=0, zero=1 (S2 data cleared).
- S1 data may be left uninitialised.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear after it.
REQ-028 First input handshake possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package / include file cla_pkg SHALL hold:
- GROUP_W = 4;
- the localparam NUM_GROUPS = WIDTH/GROUP;
- function/macros for group P/G.
REQ-030 One sub-module: cla_group_pg (parametrised by GROUP).
- Outputs: per-bit carries plus group propagate and group generate.
- Instantiated NUM_GROUPS times in stage 1 and once at the group-of-groups level.
REQ-031 Width/parameter legality SHALL be checked by an elaboration-time assertion.

Verification
REQ-032 WIDTH=32, sub=0, a=0xFFFFFFFF, b=0x00000001, c_in=0 -> after 2 cycles: sum=0, c_out=1, overflow=0, zero=1.
REQ-033 sub=0, a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, c_out=0; sub=1, a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
REQ-034 Stream 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, starting 2 cycles after the first handshake.
REQ-035 Hold out_ready=0 for 5 cycles with 3 beats offered:
- expect in_ready=0 after 2 accepted beats;
- outputs held stable;
- release -> all 3 results delivered in order, none lost or duplicated.
REQ-036 Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 asynchronously, in_ready=1, sum=0, zero=1; neither beat emerges afterwards.
REQ-037 Run 10^5 random beats with random in_valid/out_ready and WIDTH in {8,16,32,64} against a behavioural a+b model, checking every output field.
